// File: rtl/rate_limiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rate_limiter_pkg
// Description : Shared widths and the per-channel state record for the
//               rate-limited ramp scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package rate_limiter_pkg;

  localparam int NUM_CH  = 4;
  localparam int DATA_W  = 6;
  localparam int STEP_W  = 3;
  localparam int CH_ID_W = 2;

  // Everything one channel needs to ramp toward its target.
  typedef struct packed {
    logic [DATA_W-1:0] target;
    logic [STEP_W-1:0] step;
    logic [DATA_W-1:0] cur;
    logic              busy;
  } ch_state_t;

endpackage
`default_nettype wire

// File: rtl/rate_limiter_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : rate_limiter_scheduler_if
// Description : Request / status bundle of the ramp scheduler. The master
//               side issues per-channel targets, the slave side reports
//               current values, completion pulses and the active grant.
// Revision    : 1.0 - initial release
// ============================================================================
interface rate_limiter_scheduler_if;
  import rate_limiter_pkg::*;

  logic [NUM_CH-1:0]        req_valid;
  logic [NUM_CH-1:0]        req_ready;
  logic [NUM_CH*DATA_W-1:0] req_target;
  logic [NUM_CH*STEP_W-1:0] req_step;
  logic [NUM_CH*DATA_W-1:0] ch_out;
  logic [NUM_CH-1:0]        done;
  logic                     grant_valid;
  logic [CH_ID_W-1:0]       grant_id;

  modport master (
    output req_valid, req_target, req_step,
    input  req_ready, ch_out, done, grant_valid, grant_id
  );

  modport slave (
    input  req_valid, req_target, req_step,
    output req_ready, ch_out, done, grant_valid, grant_id
  );

endinterface
`default_nettype wire

// File: rtl/rate_limiter_scheduler_step_engine.sv
`default_nettype none
// ============================================================================
// Module      : rl_step_engine
// Description : Combinational single-step move of a value toward its target.
//               The move is limited to the distance left, so the result can
//               never overshoot the target or wrap past either rail.
// Revision    : 1.0 - initial release
// ============================================================================
module rl_step_engine
  import rate_limiter_pkg::*;
(
  input  logic [DATA_W-1:0] cur,
  input  logic [DATA_W-1:0] target,
  input  logic [STEP_W-1:0] step,
  output logic [DATA_W-1:0] next_cur,
  output logic              at_target
);

  // One guard bit keeps the subtraction paths from aliasing near 0 and 63.
  localparam int c_CALC_W = DATA_W + 1;

  logic [c_CALC_W-1:0] w_cur;
  logic [c_CALC_W-1:0] w_tgt;
  logic [c_CALC_W-1:0] w_step;
  logic [c_CALC_W-1:0] w_dist;
  logic [c_CALC_W-1:0] w_move;
  logic [c_CALC_W-1:0] w_next;

  // Move by min(step, distance) in the direction of the target.
  always_comb begin
    w_cur  = c_CALC_W'(cur);
    w_tgt  = c_CALC_W'(target);
    w_step = c_CALC_W'(step);
    w_dist = (w_tgt >= w_cur) ? (w_tgt - w_cur) : (w_cur - w_tgt);
    w_move = (w_step < w_dist) ? w_step : w_dist;
    if (w_tgt > w_cur) begin
      w_next = w_cur + w_move;
    end else begin
      w_next = w_cur - w_move;
    end
  end

  assign next_cur  = w_next[DATA_W-1:0];
  // A zero step can never make progress, so it is retired immediately.
  assign at_target = (step == '0) || (w_next == w_tgt);

endmodule
`default_nettype wire

// File: rtl/rate_limiter_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : rate_limiter_scheduler
// Description : Four independent ramp channels sharing one step engine.
//               Each cycle at most one busy channel is granted, round-robin,
//               and its value moves one step toward its target.
// Revision    : 1.0 - initial release
// ============================================================================
module rate_limiter_scheduler
  import rate_limiter_pkg::*;
(
  input logic                     clk,
  input logic                     rst,
  rate_limiter_scheduler_if.slave bus
);

  ch_state_t          r_ch [NUM_CH];
  logic [CH_ID_W-1:0] r_last;
  logic [NUM_CH-1:0]  r_done;

  logic               w_grant_valid;
  logic [CH_ID_W-1:0] w_grant_id;
  logic [CH_ID_W-1:0] w_cand;
  ch_state_t          w_sel;
  logic [DATA_W-1:0]  w_next_cur;
  logic               w_at_target;
  logic [NUM_CH*DATA_W-1:0] w_ch_out;
  logic [NUM_CH-1:0]  w_ready;

  // Round-robin arbiter: search starts one past the last granted channel.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_id    = '0;
    w_cand        = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      w_cand = r_last + CH_ID_W'(k);
      if (!w_grant_valid && r_ch[w_cand].busy) begin
        w_grant_valid = 1'b1;
        w_grant_id    = w_cand;
      end
    end
  end

  assign w_sel = r_ch[w_grant_id];

  rl_step_engine u_step_engine (
    .cur       (w_sel.cur),
    .target    (w_sel.target),
    .step      (w_sel.step),
    .next_cur  (w_next_cur),
    .at_target (w_at_target)
  );

  // Flatten channel state onto the output buses.
  always_comb begin
    w_ch_out = '0;
    w_ready  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_ch_out[i*DATA_W +: DATA_W] = r_ch[i].cur;
      w_ready[i]                   = ~r_ch[i].busy;
    end
  end

  // Channel state: accept idle requests, apply the granted step, pulse done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_ch[i] <= '0;
      end
      r_done <= '0;
      // Last grant parked on the top channel so channel 0 wins first.
      r_last <= CH_ID_W'(NUM_CH - 1);
    end else begin
      r_done <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.req_valid[i] && !r_ch[i].busy) begin
          r_ch[i].target <= bus.req_target[i*DATA_W +: DATA_W];
          r_ch[i].step   <= bus.req_step[i*STEP_W +: STEP_W];
          r_ch[i].busy   <= 1'b1;
        end
      end
      // A granted channel is busy, so it never collides with an accept above.
      if (w_grant_valid) begin
        r_ch[w_grant_id].cur <= w_next_cur;
        r_last               <= w_grant_id;
        if (w_at_target) begin
          r_ch[w_grant_id].busy <= 1'b0;
          r_done[w_grant_id]    <= 1'b1;
        end
      end
    end
  end

  assign bus.ch_out      = w_ch_out;
  assign bus.req_ready   = w_ready;
  assign bus.done        = r_done;
  assign bus.grant_valid = w_grant_valid;
  assign bus.grant_id    = w_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_rate_limiter_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_rate_limiter_scheduler
// Description : Scoreboard bench for the ramp scheduler. Stimulus queues the
//               hand-computed result of every grant; a negedge monitor pops
//               one entry for each grant seen and checks the value, the
//               granted channel and the done vector that follow it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rate_limiter_scheduler;

  typedef struct {
    int id;
    int val;
    bit dn;
  } exp_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  exp_t q[$];

  rate_limiter_scheduler_if bus ();

  rate_limiter_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic push(input int id, input int val, input bit dn);
    exp_t e;
    e.id  = id;
    e.val = val;
    e.dn  = dn;
    q.push_back(e);
  endtask

  // Entered and left at posedge+2: request held across exactly one edge.
  task automatic issue(input int ch, input int tgt, input int st);
    logic [5:0] t6;
    logic [2:0] s3;
    t6 = 6'(tgt);
    s3 = 3'(st);
    bus.req_target[ch*6 +: 6] = t6;
    bus.req_step[ch*3 +: 3]   = s3;
    bus.req_valid[ch]         = 1'b1;
    @(posedge clk);
    #2;
    bus.req_valid = '0;
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while (q.size() != 0 && n < max) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d entries left, required 0", q.size());
      q.delete();
    end
    @(posedge clk);
    #2;
  endtask

  // Monitor: a grant seen at one negedge is checked at the next one.
  initial begin : monitor
    bit         pend;
    int         pend_id;
    exp_t       e;
    logic [5:0] v;
    logic [3:0] dexp;
    pend    = 1'b0;
    pend_id = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("rst_ch_out", 32'(bus.ch_out), 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'hF);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_grant_valid", 32'(bus.grant_valid), 32'd0);
        chk("rst_grant_id", 32'(bus.grant_id), 32'd0);
        pend = 1'b0;
      end else begin
        if (pend) begin
          if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_grant: got grant of ch%0d, required none", pend_id);
          end else begin
            e    = q.pop_front();
            v    = bus.ch_out[pend_id*6 +: 6];
            dexp = e.dn ? 4'(1 << e.id) : 4'd0;
            chk("grant_id", 32'(pend_id), 32'(e.id));
            chk("ch_out", 32'(v), 32'(e.val));
            chk("done", 32'(bus.done), 32'(dexp));
          end
        end else begin
          chk("idle_done", 32'(bus.done), 32'd0);
        end
        pend    = bus.grant_valid;
        pend_id = int'(bus.grant_id);
      end
    end
  end

  initial begin : stimulus
    n_tests        = 0;
    n_fail         = 0;
    rst            = 1'b0;
    bus.req_valid  = '0;
    bus.req_target = '0;
    bus.req_step   = '0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    chk("init_ready", 32'(bus.req_ready), 32'hF);
    chk("init_ch_out", 32'(bus.ch_out), 32'd0);
    chk("init_grant_valid", 32'(bus.grant_valid), 32'd0);

    // Ramp up 0 -> 30 by 7, last step clamped.
    push(0, 7, 0); push(0, 14, 0); push(0, 21, 0); push(0, 28, 0); push(0, 30, 1);
    issue(0, 30, 7);
    drain(40);

    // Ramp down 30 -> 15; a second request while busy must be ignored.
    push(0, 23, 0); push(0, 16, 0); push(0, 15, 1);
    issue(0, 15, 7);
    chk("busy_ready0", 32'(bus.req_ready[0]), 32'd0);
    issue(0, 63, 1);
    drain(40);

    // Near-rail moves: 2 -> 0 and 60 -> 63 in one clamped step each.
    push(1, 2, 1);
    issue(1, 2, 6);
    drain(40);
    push(1, 0, 1);
    issue(1, 0, 6);
    drain(40);
    push(2, 7, 0); push(2, 14, 0); push(2, 21, 0); push(2, 28, 0); push(2, 35, 0);
    push(2, 42, 0); push(2, 49, 0); push(2, 56, 0); push(2, 60, 1);
    issue(2, 60, 7);
    drain(40);
    push(2, 63, 1);
    issue(2, 63, 7);
    drain(40);

    // Degenerate requests: step 0, and target already reached.
    push(1, 0, 1);
    issue(1, 40, 0);
    drain(40);
    push(3, 0, 1);
    issue(3, 0, 5);
    drain(40);

    // All four at once from ch0=15, ch1=0, ch2=63, ch3=0; last grant was ch3.
    push(0, 18, 0); push(1, 2, 0); push(2, 59, 0); push(3, 3, 0);
    push(0, 21, 0); push(1, 4, 0); push(2, 57, 1); push(3, 6, 0);
    push(0, 22, 1); push(1, 5, 1); push(3, 9, 1);
    bus.req_target = {6'd9, 6'd57, 6'd5, 6'd22};
    bus.req_step   = {3'd3, 3'd4, 3'd2, 3'd3};
    bus.req_valid  = 4'hF;
    @(posedge clk);
    #2;
    bus.req_valid = '0;
    drain(60);

    // Reset mid-ramp: ch3 9 -> 15 -> 21, then reset before the next step lands.
    push(3, 15, 0); push(3, 21, 0);
    issue(3, 40, 6);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    chk("post_rst_queue", 32'(q.size()), 32'd0);
    chk("post_rst_ready", 32'(bus.req_ready), 32'hF);
    chk("post_rst_ch_out", 32'(bus.ch_out), 32'd0);

    // Ramp restarts from 0.
    push(3, 7, 0); push(3, 14, 0); push(3, 21, 0); push(3, 28, 0); push(3, 35, 0);
    push(3, 40, 1);
    issue(3, 40, 7);
    drain(40);
    chk("final_ready", 32'(bus.req_ready), 32'hF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
